// File: rtl/lcd_bus_reader.sv
// Purpose: read-side HD44780-style LCD bus sequencer with optional busy-flag polling (timeout feature: LCD_RD_TIMEOUT_EN).
// Latency: iStart to oDone is 1+T_AS+T_EH+T_EL cycles per access; polling adds T_AS+T_EH+T_EL per extra access.
// Backpressure: none; iStart is ignored while oBusy=1, and LCD_DATA is sampled on the last EN_HI cycle only.
module lcd_bus_reader #(
    parameter int T_AS      = 3,
    parameter int T_EH      = 25,
    parameter int T_EL      = 25,
    parameter int MAX_POLLS = 4096
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    input  logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic [7:0] oData,
    output logic       oBF,
    output logic [6:0] oAddr,
    output logic       oBusy,
    output logic       oDone,
    output logic       oTimeout
);

    localparam int T_MAX01 = (T_AS > T_EH) ? T_AS : T_EH;
    localparam int T_MAX   = (T_MAX01 > T_EL) ? T_MAX01 : T_EL;
    localparam int CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EN_HI = 3'd2,
        EN_LO = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          take_start;
    logic          sample;
    logic          poll_q;
    logic          poll_again;
    logic          poll_last;

    // Another access is needed only for a polled status read that still saw BF=1.
    assign poll_again = poll_q && !LCD_RS && oData[7];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        take_start = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    state_nxt  = SETUP;
                    cnt_nxt    = CW'(T_AS - 1);
                    take_start = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = EN_HI;
                    cnt_nxt   = CW'(T_EH - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            EN_HI: begin
                if (cnt == '0) begin
                    state_nxt = EN_LO;
                    cnt_nxt   = CW'(T_EL - 1);
                    sample    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            EN_LO: begin
                if (cnt == '0) begin
                    if (poll_again && !poll_last) begin
                        state_nxt = SETUP;
                        cnt_nxt   = CW'(T_AS - 1);
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Strobes are flopped from the next state so LCD_EN never sees a decode glitch.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            LCD_EN <= 1'b0;
            LCD_RW <= 1'b0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            LCD_EN <= (state_nxt == EN_HI);
            LCD_RW <= (state_nxt == SETUP) || (state_nxt == EN_HI) || (state_nxt == EN_LO);
            oBusy  <= (state_nxt != IDLE);
            oDone  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            LCD_RS <= 1'b0;
            poll_q <= 1'b0;
            oData  <= '0;
            oBF    <= 1'b0;
            oAddr  <= '0;
        end else begin
            if (take_start) begin
                LCD_RS <= iRS;
                poll_q <= iPoll;
            end
            if (sample) begin
                oData <= LCD_DATA;
                oBF   <= LCD_RS ? 1'b0 : LCD_DATA[7];
                oAddr <= LCD_RS ? 7'd0 : LCD_DATA[6:0];
            end
        end
    end

`ifdef LCD_RD_TIMEOUT_EN
    localparam int PW = $clog2(MAX_POLLS + 1);

    logic [PW-1:0] poll_cnt;
    logic          lo_end;

    assign lo_end    = (state == EN_LO) && (cnt == '0);
    assign poll_last = (poll_cnt == PW'(MAX_POLLS - 1));

    // poll_cnt holds the number of EN_LO phases already finished in this transaction.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            poll_cnt <= '0;
            oTimeout <= 1'b0;
        end else begin
            if (take_start) begin
                poll_cnt <= '0;
                oTimeout <= 1'b0;
            end else if (lo_end && poll_again) begin
                if (poll_last) begin
                    oTimeout <= 1'b1;
                end else begin
                    poll_cnt <= poll_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign poll_last = 1'b0;
    assign oTimeout  = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: reset, data/status reads, polling, timeout, ignored starts and sample window.
module tb_lcd_bus_reader;

    localparam int T_AS      = 3;
    localparam int T_EH      = 25;
    localparam int T_EL      = 25;
    localparam int MAX_POLLS = 4;
    localparam int ACC       = T_AS + T_EH + T_EL;
    localparam int LAT       = 1 + ACC;
    localparam int LIMIT     = 2000;

    logic       iCLK;
    logic       iRST;
    logic       iStart;
    logic       iRS;
    logic       iPoll;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    logic [7:0] oData;
    logic       oBF;
    logic [6:0] oAddr;
    logic       oBusy;
    logic       oDone;
    logic       oTimeout;

    int total = 0;
    int bad   = 0;

    lcd_bus_reader #(
        .T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL), .MAX_POLLS(MAX_POLLS)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
        .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS),
        .oData(oData), .oBF(oBF), .oAddr(oAddr), .oBusy(oBusy), .oDone(oDone),
        .oTimeout(oTimeout)
    );

    initial begin
        iCLK = 1'b0;
        forever #10 iCLK = ~iCLK;
    end

    // mode 0: access k (1-based) sees d_a while k<=n_a, else d_b
    // mode 1: LCD_DATA switches to d_b during the first SETUP
    // mode 2: LCD_DATA switches to d_b during the first EN_LO
    // mode 3: a second iStart (with flipped iRS) is issued mid EN_HI
    task automatic run_txn(input logic rs, input logic poll, input int mode,
                           input logic [7:0] d_a, input logic [7:0] d_b, input int n_a,
                           output int cyc, output int pulses, output int en_hi, output int stab_bad);
        logic en_prev;
        LCD_DATA = d_a;
        @(negedge iCLK);
        iRS = rs; iPoll = poll; iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        cyc = 1; pulses = 0; en_hi = 0; stab_bad = 0; en_prev = 1'b0;
        while (oDone !== 1'b1 && cyc < LIMIT) begin
            iStart = 1'b0;
            if (LCD_EN === 1'b1) en_hi++;
            if (LCD_EN === 1'b1 && !en_prev) begin
                pulses++;
                if (mode == 0) LCD_DATA = (pulses <= n_a) ? d_a : d_b;
            end
            if (oBusy === 1'b1 && (LCD_RW !== 1'b1 || LCD_RS !== rs)) stab_bad++;
            if (mode == 1 && LCD_EN === 1'b0 && pulses == 0) LCD_DATA = d_b;
            if (mode == 2 && LCD_EN === 1'b0 && pulses == 1) LCD_DATA = d_b;
            if (mode == 3 && LCD_EN === 1'b1 && en_hi == 5) begin
                iStart = 1'b1; iRS = ~rs; iPoll = 1'b1;
            end
            en_prev = (LCD_EN === 1'b1);
            @(negedge iCLK);
            cyc++;
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1; iStart = 1'b0; iRS = 1'b0; iPoll = 1'b0; LCD_DATA = 8'h00;
        @(negedge iCLK);
        total++; if ({LCD_EN, LCD_RW, LCD_RS} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b expected 000", {LCD_EN, LCD_RW, LCD_RS}); end
        total++; if ({oBusy, oDone, oTimeout, oBF} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b expected 0000", {oBusy, oDone, oTimeout, oBF}); end
        total++; if (oData !== 8'h00 || oAddr !== 7'h00) begin bad++; $display("FAIL reset_data: got %h/%h expected 00/00", oData, oAddr); end
        iRST = 1'b0;
        repeat (5) @(negedge iCLK);
        total++; if (oBusy !== 1'b0 || LCD_RW !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got busy=%b rw=%b expected 0/0", oBusy, LCD_RW); end
    endtask

    task automatic test_single_read();
        int cyc, pulses, en_hi, stab;
        run_txn(1'b1, 1'b0, 0, 8'h41, 8'h41, 99, cyc, pulses, en_hi, stab);
        total++; if (cyc !== LAT) begin bad++; $display("FAIL read_latency: got %0d expected %0d", cyc, LAT); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL read_pulses: got %0d expected 1", pulses); end
        total++; if (en_hi !== T_EH) begin bad++; $display("FAIL read_en_width: got %0d expected %0d", en_hi, T_EH); end
        total++; if (stab !== 0) begin bad++; $display("FAIL read_rs_rw_stable: got %0d bad cycles expected 0", stab); end
        total++; if (oData !== 8'h41 || oBF !== 1'b0 || oAddr !== 7'h00) begin bad++; $display("FAIL read_result: got %h/%b/%h expected 41/0/00", oData, oBF, oAddr); end
        total++; if (LCD_RW !== 1'b0 || LCD_RS !== 1'b1 || oBusy !== 1'b1) begin bad++; $display("FAIL done_cycle: got rw=%b rs=%b busy=%b expected 0/1/1", LCD_RW, LCD_RS, oBusy); end
        @(negedge iCLK);
        total++; if (oDone !== 1'b0 || oBusy !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got done=%b busy=%b expected 0/0", oDone, oBusy); end
        LCD_DATA = 8'hFF;
        repeat (5) @(negedge iCLK);
        total++; if (oData !== 8'h41) begin bad++; $display("FAIL data_hold_idle: got %h expected 41", oData); end
        run_txn(1'b1, 1'b0, 0, 8'hC5, 8'hC5, 99, cyc, pulses, en_hi, stab);
        total++; if (oData !== 8'hC5 || oBF !== 1'b0 || oAddr !== 7'h00) begin bad++; $display("FAIL data_read_no_bf: got %h/%b/%h expected C5/0/00", oData, oBF, oAddr); end
    endtask

    task automatic test_status_read();
        int cyc, pulses, en_hi, stab;
        run_txn(1'b0, 1'b0, 0, 8'h85, 8'h85, 99, cyc, pulses, en_hi, stab);
        total++; if (cyc !== LAT || pulses !== 1) begin bad++; $display("FAIL status_nopoll: got cyc=%0d pulses=%0d expected %0d/1", cyc, pulses, LAT); end
        total++; if (oBF !== 1'b1 || oAddr !== 7'h05 || oData !== 8'h85) begin bad++; $display("FAIL status_result: got %b/%h/%h expected 1/05/85", oBF, oAddr, oData); end
        total++; if (stab !== 0) begin bad++; $display("FAIL status_rs_rw_stable: got %0d expected 0", stab); end
    endtask

    task automatic test_poll();
        int cyc, pulses, en_hi, stab;
        run_txn(1'b0, 1'b1, 0, 8'h85, 8'h05, 3, cyc, pulses, en_hi, stab);
        total++; if (pulses !== 4) begin bad++; $display("FAIL poll_pulses: got %0d expected 4", pulses); end
        total++; if (cyc !== 1 + 4 * ACC) begin bad++; $display("FAIL poll_latency: got %0d expected %0d", cyc, 1 + 4 * ACC); end
        total++; if (oBF !== 1'b0 || oAddr !== 7'h05 || oTimeout !== 1'b0) begin bad++; $display("FAIL poll_result: got bf=%b addr=%h to=%b expected 0/05/0", oBF, oAddr, oTimeout); end
        total++; if (en_hi !== 4 * T_EH || stab !== 0) begin bad++; $display("FAIL poll_strobes: got en_hi=%0d stab=%0d expected %0d/0", en_hi, stab, 4 * T_EH); end
    endtask

    task automatic test_timeout();
        int cyc, pulses, en_hi, stab;
`ifdef LCD_RD_TIMEOUT_EN
        run_txn(1'b0, 1'b1, 0, 8'h80, 8'h80, 99, cyc, pulses, en_hi, stab);
        total++; if (pulses !== MAX_POLLS) begin bad++; $display("FAIL timeout_pulses: got %0d expected %0d", pulses, MAX_POLLS); end
        total++; if (cyc !== 1 + MAX_POLLS * ACC) begin bad++; $display("FAIL timeout_latency: got %0d expected %0d", cyc, 1 + MAX_POLLS * ACC); end
        total++; if (oTimeout !== 1'b1 || oBF !== 1'b1) begin bad++; $display("FAIL timeout_flag: got to=%b bf=%b expected 1/1", oTimeout, oBF); end
        repeat (3) @(negedge iCLK);
        total++; if (oTimeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b expected 1", oTimeout); end
        run_txn(1'b1, 1'b0, 0, 8'h41, 8'h41, 99, cyc, pulses, en_hi, stab);
        total++; if (oTimeout !== 1'b0) begin bad++; $display("FAIL timeout_clear_on_start: got %b expected 0", oTimeout); end
`else
        run_txn(1'b0, 1'b1, 0, 8'h80, 8'h00, 6, cyc, pulses, en_hi, stab);
        total++; if (pulses !== 7) begin bad++; $display("FAIL poll_no_limit_pulses: got %0d expected 7", pulses); end
        total++; if (cyc !== 1 + 7 * ACC) begin bad++; $display("FAIL poll_no_limit_latency: got %0d expected %0d", cyc, 1 + 7 * ACC); end
        total++; if (oTimeout !== 1'b0 || oBF !== 1'b0) begin bad++; $display("FAIL poll_no_limit_flags: got to=%b bf=%b expected 0/0", oTimeout, oBF); end
`endif
    endtask

    task automatic test_start_while_busy();
        int cyc, pulses, en_hi, stab, extra;
        run_txn(1'b1, 1'b0, 3, 8'h41, 8'h41, 99, cyc, pulses, en_hi, stab);
        total++; if (pulses !== 1 || cyc !== LAT) begin bad++; $display("FAIL busy_start_ignored: got pulses=%0d cyc=%0d expected 1/%0d", pulses, cyc, LAT); end
        total++; if (stab !== 0) begin bad++; $display("FAIL busy_start_rs_resampled: got %0d bad cycles expected 0", stab); end
        extra = 0;
        repeat (10) begin
            @(negedge iCLK);
            if (oBusy === 1'b1 || oDone === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL busy_start_second_txn: got %0d busy cycles expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int cyc, pulses, en_hi, stab;
        run_txn(1'b0, 1'b0, 0, 8'h23, 8'h23, 99, cyc, pulses, en_hi, stab);
        run_txn(1'b1, 1'b0, 0, 8'h9C, 8'h9C, 99, cyc, pulses, en_hi, stab);
        total++; if (cyc !== LAT || oData !== 8'h9C || oBF !== 1'b0) begin bad++; $display("FAIL back_to_back: got cyc=%0d data=%h bf=%b expected %0d/9C/0", cyc, oData, oBF, LAT); end
    endtask

    task automatic test_sample_window();
        int cyc, pulses, en_hi, stab;
        run_txn(1'b1, 1'b0, 1, 8'hAA, 8'h55, 99, cyc, pulses, en_hi, stab);
        total++; if (oData !== 8'h55) begin bad++; $display("FAIL change_in_setup: got %h expected 55", oData); end
        run_txn(1'b1, 1'b0, 2, 8'hAA, 8'h55, 99, cyc, pulses, en_hi, stab);
        total++; if (oData !== 8'hAA) begin bad++; $display("FAIL change_in_en_lo: got %h expected AA", oData); end
    endtask

    task automatic test_reset_mid();
        int cyc, pulses, en_hi, stab;
        @(negedge iCLK);
        iRS = 1'b1; iPoll = 1'b0; iStart = 1'b1; LCD_DATA = 8'h77;
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (10) @(negedge iCLK);
        total++; if (LCD_EN !== 1'b1) begin bad++; $display("FAIL mid_en_hi_reached: got %b expected 1", LCD_EN); end
        #3 iRST = 1'b1;
        #1;
        total++; if (LCD_EN !== 1'b0 || LCD_RW !== 1'b0 || LCD_RS !== 1'b0) begin bad++; $display("FAIL async_reset_strobes: got %b%b%b expected 000", LCD_EN, LCD_RW, LCD_RS); end
        total++; if (oBusy !== 1'b0 || oData !== 8'h00 || oDone !== 1'b0) begin bad++; $display("FAIL async_reset_state: got busy=%b data=%h done=%b expected 0/00/0", oBusy, oData, oDone); end
        @(negedge iCLK);
        iStart = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0; iStart = 1'b0;
        repeat (5) @(negedge iCLK);
        total++; if (oBusy !== 1'b0 || LCD_RW !== 1'b0) begin bad++; $display("FAIL reset_beats_start: got busy=%b rw=%b expected 0/0", oBusy, LCD_RW); end
        run_txn(1'b1, 1'b0, 0, 8'h41, 8'h41, 99, cyc, pulses, en_hi, stab);
        total++; if (cyc !== LAT || oData !== 8'h41) begin bad++; $display("FAIL read_after_reset: got cyc=%0d data=%h expected %0d/41", cyc, oData, LAT); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_status_read();
        test_poll();
        test_timeout();
        test_start_while_busy();
        test_back_to_back();
        test_sample_window();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
